// File: rtl/techlib_arst_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : techlib_arst_sequencer
// Purpose  : Reset generator for the techlib async-reset flops. It asserts a
//            bank of ARST outputs asynchronously and releases them one stage
//            at a time, synchronous to CLK: first a hold window, then a fixed
//            gap between stages. READY goes high once every stage is released.
// Revision : 1.0 - initial release
// ============================================================================
module techlib_arst_sequencer #(
  parameter int   STAGES       = 4,
  parameter int   SYNC_DEPTH   = 2,
  parameter int   HOLD_CYCLES  = 16,
  parameter int   GAP_CYCLES   = 4,
  parameter logic OUT_POLARITY = 1'b1
) (
  input  logic              CLK,
  input  logic              ARST,
  input  logic              SW_RST,
  output logic [STAGES-1:0] ARST_OUT,
  output logic              READY
);

  // Counter and stage-index widths
  localparam int c_cnt_max = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
  localparam int c_idx_w   = $clog2(STAGES + 1);
  // The state register's move into HOLD is the last synchronizer stage, so
  // the explicit chain is one flop shorter than SYNC_DEPTH.
  localparam int c_sync_w  = SYNC_DEPTH - 1;

  localparam logic [c_cnt_w-1:0] c_hold_tc  = c_cnt_w'(HOLD_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_gap_tc   = c_cnt_w'(GAP_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_sat  = c_cnt_w'(c_cnt_max);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(STAGES - 1);
  localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);
  localparam logic [STAGES-1:0]  c_all_asserted = {STAGES{OUT_POLARITY}};

  localparam logic [2:0] S_RESET   = 3'd0;
  localparam logic [2:0] S_SYNC    = 3'd1;
  localparam logic [2:0] S_HOLD    = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_RUN     = 3'd4;

  // Illegal parameterisations stop elaboration
  if (STAGES < 1) begin : g_chk_stages
    $error("techlib_arst_sequencer: STAGES must be >= 1");
  end
  if (SYNC_DEPTH < 2) begin : g_chk_sync
    $error("techlib_arst_sequencer: SYNC_DEPTH must be >= 2");
  end
  if (HOLD_CYCLES < 1) begin : g_chk_hold
    $error("techlib_arst_sequencer: HOLD_CYCLES must be >= 1");
  end
  if (GAP_CYCLES < 1) begin : g_chk_gap
    $error("techlib_arst_sequencer: GAP_CYCLES must be >= 1");
  end

  logic [2:0]          r_state;
  logic [2:0]          w_state_nxt;
  logic [c_sync_w-1:0] r_sync;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_cnt_w-1:0]  w_cnt_nxt;
  logic [c_cnt_w-1:0]  w_cnt_inc;
  logic [c_idx_w-1:0]  r_idx;
  logic [c_idx_w-1:0]  w_idx_nxt;
  logic [STAGES-1:0]   r_out;
  logic [STAGES-1:0]   w_out_nxt;
  logic                r_ready;
  logic                w_ready_nxt;
  logic                w_sw_active;
  logic                w_sync_hi;

  // Software reset only counts once the block has left the sync phase
  assign w_sw_active = SW_RST && ((r_state == S_HOLD) || (r_state == S_RELEASE) ||
                                  (r_state == S_RUN));
  assign w_sync_hi   = r_sync[c_sync_w-1];
  // Saturating increment keeps the counter from wrapping into a false release
  assign w_cnt_inc   = (r_cnt == c_cnt_sat) ? r_cnt : r_cnt + c_cnt_w'(1);

  // State register, forced to RESET while ARST is low
  always_ff @(posedge CLK or negedge ARST) begin
    if (!ARST) begin
      r_state <= S_RESET;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    if (w_sw_active) begin
      w_state_nxt = S_HOLD;
    end else begin
      case (r_state)
        S_RESET:   w_state_nxt = S_SYNC;
        S_SYNC:    if (w_sync_hi) w_state_nxt = S_HOLD;
        S_HOLD:    if (r_cnt == c_hold_tc) w_state_nxt = (STAGES == 1) ? S_RUN : S_RELEASE;
        S_RELEASE: if ((r_cnt == c_gap_tc) && (r_idx == c_last_idx)) w_state_nxt = S_RUN;
        S_RUN:     w_state_nxt = S_RUN;
        default:   w_state_nxt = S_RESET;
      endcase
    end
  end

  // Next values of counter, stage index and the registered outputs
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_out_nxt   = r_out;
    w_ready_nxt = r_ready;
    if (w_sw_active) begin
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
      w_out_nxt   = c_all_asserted;
      w_ready_nxt = 1'b0;
    end else begin
      case (r_state)
        S_HOLD: begin
          if (r_cnt == c_hold_tc) begin
            w_cnt_nxt    = '0;
            w_idx_nxt    = c_idx_one;
            w_out_nxt[0] = ~OUT_POLARITY;
            w_ready_nxt  = (STAGES == 1);
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        S_RELEASE: begin
          if (r_cnt == c_gap_tc) begin
            w_cnt_nxt = '0;
            w_idx_nxt = r_idx + c_idx_one;
            for (int k = 0; k < STAGES; k++) begin
              if (r_idx == c_idx_w'(k)) w_out_nxt[k] = ~OUT_POLARITY;
            end
            if (r_idx == c_last_idx) w_ready_nxt = 1'b1;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        S_RUN: begin
          w_cnt_nxt = '0;
        end
        default: begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_out_nxt   = c_all_asserted;
          w_ready_nxt = 1'b0;
        end
      endcase
    end
  end

  // Datapath and output flops; async assert, sync release
  always_ff @(posedge CLK or negedge ARST) begin
    if (!ARST) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_out   <= c_all_asserted;
      r_ready <= 1'b0;
    end else begin
      r_sync  <= c_sync_w'({r_sync, 1'b1});
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_out   <= w_out_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  assign ARST_OUT = r_out;
  assign READY    = r_ready;

endmodule
`default_nettype wire
